// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared Hamming(21,16) constants, syndrome and encode helpers
// Purpose: code geometry, parity/data index maps and the syndrome function
//          shared by the encoder and decoder sides of the link.
// Ports:   none (package).
package hamming_pkg;
  localparam int HAM_N = 21;
  localparam int HAM_K = 16;
  localparam int HAM_P = 5;

  // Codeword bit i carries Hamming position i+1; parity sits at positions 2^j.
  localparam int PARITY_IDX [HAM_P] = '{0, 1, 3, 7, 15};
  localparam int DATA_IDX [HAM_K] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14,
                                      16, 17, 18, 19, 20};

  // XOR-accumulating the 1-based position of every set bit evaluates all five
  // even-parity checks at once.
  function automatic logic [HAM_P-1:0] ham_syndrome(input logic [HAM_N-1:0] cw);
    logic [HAM_P-1:0] s;
    s = '0;
    for (int i = 0; i < HAM_N; i++) begin
      s = s ^ ({HAM_P{cw[i]}} & HAM_P'(i + 1));
    end
    return s;
  endfunction

  function automatic logic [HAM_K-1:0] ham_extract(input logic [HAM_N-1:0] cw);
    logic [HAM_K-1:0] d;
    d = '0;
    for (int k = 0; k < HAM_K; k++) begin
      d[k] = cw[DATA_IDX[k]];
    end
    return d;
  endfunction

  function automatic logic [HAM_N-1:0] ham_encode(input logic [HAM_K-1:0] d);
    logic [HAM_N-1:0] cw;
    logic [HAM_P-1:0] s;
    cw = '0;
    for (int k = 0; k < HAM_K; k++) begin
      cw[DATA_IDX[k]] = d[k];
    end
    // Parity bits are still zero here, so the syndrome is exactly the parity needed.
    s = ham_syndrome(cw);
    for (int p = 0; p < HAM_P; p++) begin
      cw[PARITY_IDX[p]] = s[p];
    end
    return cw;
  endfunction
endpackage

// File: rtl/hamming_syndrome.sv
// rtl/hamming_syndrome.sv - combinational 5-bit syndrome of a 21-bit codeword
// Purpose: syndrome generator used by the decoder's first stage.
// Ports:   codeword_i - received codeword, bit i is Hamming position i+1
//          syndrome_o - 5-bit syndrome (0 = clean, else error position)
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [HAM_N-1:0] codeword_i,
  output logic [HAM_P-1:0] syndrome_o
);

  assign syndrome_o = ham_syndrome(codeword_i);

endmodule

// File: rtl/hamming_decoder.sv
// rtl/hamming_decoder.sv - two-stage SEC Hamming(21,16) decoder with error counters
// Purpose: accepts codewords on a valid/ready stream, corrects single-bit
//          errors, flags out-of-range syndromes and counts both events.
// Ports:   clk, rst                  - clock, asynchronous active-high reset
//          in_valid/in_ready         - codeword input handshake
//          codeword_in               - received 21-bit codeword
//          out_valid/out_ready       - result output handshake
//          data_out                  - corrected 16-bit data
//          err_corrected, err_uncorr - result flags, qualified by out_valid
//          syndrome_out              - raw syndrome of the result
//          cnt_clear                 - synchronous clear of both counters
//          cnt_corrected, cnt_uncorr - saturating event counters
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [HAM_N-1:0] codeword_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [HAM_K-1:0] data_out,
  output logic             err_corrected,
  output logic             err_uncorr,
  output logic [HAM_P-1:0] syndrome_out,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid_q;
  logic [HAM_N-1:0] s1_cw_q;
  logic [HAM_P-1:0] s1_syn_q;
  logic [HAM_P-1:0] in_syn;
  logic             advance;
  logic             is_corr;
  logic             is_uncorr;
  logic [HAM_N-1:0] flip_mask;
  logic [CNT_W-1:0] cnt_corr_d;
  logic [CNT_W-1:0] cnt_unc_d;

  hamming_syndrome u_syndrome (
    .codeword_i (codeword_in),
    .syndrome_o (in_syn)
  );

  // Both stages move together; the only stall source is a held result.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    is_corr   = (s1_syn_q != '0) && (s1_syn_q <= HAM_P'(HAM_N));
    is_uncorr = s1_syn_q > HAM_P'(HAM_N);
    flip_mask = '0;
    if (is_corr) begin
      flip_mask = HAM_N'(1) << (s1_syn_q - 1'b1);
    end
  end

  always_comb begin
    cnt_corr_d = cnt_corrected;
    cnt_unc_d  = cnt_uncorr;
    if (cnt_clear) begin
      cnt_corr_d = '0;
      cnt_unc_d  = '0;
    end else if (advance && s1_valid_q) begin
      if (is_corr && (cnt_corrected != CNT_MAX)) begin
        cnt_corr_d = cnt_corrected + 1'b1;
      end
      if (is_uncorr && (cnt_uncorr != CNT_MAX)) begin
        cnt_unc_d = cnt_uncorr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_cw_q       <= '0;
      s1_syn_q      <= '0;
      out_valid     <= 1'b0;
      data_out      <= '0;
      err_corrected <= 1'b0;
      err_uncorr    <= 1'b0;
      syndrome_out  <= '0;
      cnt_corrected <= '0;
      cnt_uncorr    <= '0;
    end else begin
      if (advance) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_cw_q  <= codeword_in;
          s1_syn_q <= in_syn;
        end
        out_valid <= s1_valid_q;
        // Bubbles leave the last result's fields in place; out_valid qualifies them.
        if (s1_valid_q) begin
          data_out      <= ham_extract(s1_cw_q ^ flip_mask);
          err_corrected <= is_corr;
          err_uncorr    <= is_uncorr;
          syndrome_out  <= s1_syn_q;
        end
      end
      cnt_corrected <= cnt_corr_d;
      cnt_uncorr    <= cnt_unc_d;
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// tb/tb_hamming_decoder.sv - self-checking bench for hamming_decoder
module tb_hamming_decoder;

  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [15:0] d;
    logic [4:0]  s;
    logic        c;
    logic        u;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [20:0]   codeword_in;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   data_out;
  logic          err_corrected;
  logic          err_uncorr;
  logic [4:0]    syndrome_out;
  logic          cnt_clear;
  logic [CW-1:0] cnt_corrected;
  logic [CW-1:0] cnt_uncorr;

  int n_checks = 0;
  int n_fail   = 0;
  int popped   = 0;

  exp_t q[$];
  int   mc = 0;
  int   mu = 0;
  logic prev_ov = 0, prev_or = 0, prev_clr = 0;
  logic hold = 0;
  logic [15:0] h_d;
  logic [4:0]  h_s;
  logic        h_c, h_u;

  hamming_decoder #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .codeword_in   (codeword_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_out      (data_out),
    .err_corrected (err_corrected),
    .err_uncorr    (err_uncorr),
    .syndrome_out  (syndrome_out),
    .cnt_clear     (cnt_clear),
    .cnt_corrected (cnt_corrected),
    .cnt_uncorr    (cnt_uncorr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference decoder: parity checks evaluated position by position, data read
  // back from every position that is not a power of two.
  function automatic exp_t model(input logic [20:0] cw);
    exp_t e;
    logic [20:0] w;
    int syn, k;
    syn = 0;
    for (int j = 0; j < 5; j++) begin
      int par;
      par = 0;
      for (int p = 1; p <= 21; p++) begin
        if (((p >> j) & 1) == 1 && cw[p-1]) par ^= 1;
      end
      syn += par << j;
    end
    w = cw;
    e.c = (syn >= 1) && (syn <= 21);
    e.u = (syn >= 22);
    if (e.c) w[syn-1] = ~w[syn-1];
    e.d = '0;
    k = 0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        e.d[k] = w[p-1];
        k++;
      end
    end
    e.s = 5'(syn);
    return e;
  endfunction

  function automatic logic [20:0] encode(input logic [15:0] d);
    logic [20:0] w;
    int k;
    w = '0;
    k = 0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p-1] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 5; j++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p <= 21; p++) begin
        if (((p >> j) & 1) == 1) par ^= w[p-1];
      end
      w[(1 << j) - 1] = par;
    end
    return w;
  endfunction

  // Scoreboard / compare process.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mc = 0; mu = 0;
      prev_ov = 0; prev_or = 0; prev_clr = 0;
      hold = 0;
    end else begin
      if (prev_clr) begin
        mc = 0; mu = 0;
      end else if (out_valid && (!prev_ov || prev_or) && q.size() > 0) begin
        if (q[0].c && mc < CMAX) mc++;
        if (q[0].u && mu < CMAX) mu++;
      end
      if (hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", data_out, h_d);
        chk("stall_syn", syndrome_out, h_s);
        chk("stall_flags", {err_corrected, err_uncorr}, {h_c, h_u});
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("sb_data", data_out, q[0].d);
          chk("sb_syn", syndrome_out, q[0].s);
          chk("sb_corr", err_corrected, q[0].c);
          chk("sb_uncorr", err_uncorr, q[0].u);
        end
      end
      chk("sb_cnt_corr", cnt_corrected, mc);
      chk("sb_cnt_uncorr", cnt_uncorr, mu);
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      hold = out_valid && !out_ready;
      h_d = data_out; h_s = syndrome_out; h_c = err_corrected; h_u = err_uncorr;
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        popped++;
      end
      if (in_valid && in_ready) q.push_back(model(codeword_in));
      prev_ov = out_valid; prev_or = out_ready; prev_clr = cnt_clear;
    end
  end

  task automatic send_check(input string nm, input logic [20:0] cw, input logic [15:0] ed,
                            input logic [4:0] es, input logic ec, input logic eu);
    int lat;
    in_valid = 1'b1; codeword_in = cw; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    chk({nm, "_latency"}, lat, 2);
    chk({nm, "_data"}, data_out, ed);
    chk({nm, "_syn"}, syndrome_out, es);
    chk({nm, "_corr"}, err_corrected, ec);
    chk({nm, "_uncorr"}, err_uncorr, eu);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    logic [20:0] wds [8];
    int idx, cyc, pstart;

    rst = 1'b1; in_valid = 1'b0; codeword_in = '0; out_ready = 1'b1; cnt_clear = 1'b0;

    m = model(21'h008020);
    chk("model_pin_syn22", m.s, 22);
    chk("model_pin_data4", m.d, 16'h0004);
    m = model(21'h1FFFFF);
    chk("model_pin_syn1", m.s, 1);
    chk("model_pin_corr", m.c, 1);
    chk("enc_pin_ones", encode(16'hFFFF), 21'h1FFFFE);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", data_out, 0);
    chk("rst_syn", syndrome_out, 0);
    chk("rst_flags", {err_corrected, err_uncorr}, 0);
    chk("rst_cnts", {cnt_corrected, cnt_uncorr}, 0);
    @(posedge clk); #1;

    send_check("zero", 21'h000000, 16'h0000, 5'd0, 0, 0);
    send_check("ones", 21'h1FFFFE, 16'hFFFF, 5'd0, 0, 0);
    chk("ones_cnts", {cnt_corrected, cnt_uncorr}, 0);
    send_check("data_err", 21'h000200, 16'h0000, 5'd10, 1, 0);
    chk("data_err_cnt", cnt_corrected, 1);
    send_check("par_err", 21'h1FFFFF, 16'hFFFF, 5'd1, 1, 0);
    chk("par_err_cnt", cnt_corrected, 2);
    send_check("uncorr", 21'h008020, 16'h0004, 5'd22, 0, 1);
    chk("uncorr_cnt", cnt_uncorr, 1);

    // Saturation at 2^CW-1.
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    chk("clear_cnt", {cnt_corrected, cnt_uncorr}, 0);
    for (int i = 0; i < 5; i++) begin
      send_check("sat", 21'(1) << i, 16'h0000, 5'(i + 1), 1, 0);
    end
    chk("sat_cnt", cnt_corrected, CMAX);

    // Clear coinciding with a flagged S2 load.
    in_valid = 1'b1; codeword_in = 21'h000400;
    @(posedge clk); #1;
    in_valid = 1'b0; cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    chk("clrhit_valid", out_valid, 1);
    chk("clrhit_corr", err_corrected, 1);
    chk("clrhit_cnt", cnt_corrected, 0);
    @(posedge clk); #1;
    chk("clrhit_cnt_after", cnt_corrected, 0);

    // Backpressure with out_ready pattern 1,0,0,1.
    for (int i = 0; i < 8; i++) begin
      wds[i] = encode((16'(i) * 16'h1111) ^ 16'hA5A5);
      if (i % 2 == 1) wds[i][2*i] = ~wds[i][2*i];
    end
    wds[7] = wds[7] ^ 21'h000006;
    idx = 0; cyc = 0; pstart = popped;
    while ((idx < 8 || q.size() > 0) && cyc < 200) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid = (idx < 8);
      if (idx < 8) codeword_in = wds[idx];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_timeout", cyc < 200, 1);
    chk("bp_count", popped - pstart, 8);

    // Reset mid-stream.
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; codeword_in = 21'(1) << (i + 5);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_cnt", cnt_corrected, 2);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_cnt", cnt_corrected, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 0);
    send_check("post_rst", 21'h1FFFFE, 16'hFFFF, 5'd0, 0, 0);

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
